roi_fft_pass_engine: RTL and testbench



---
 rtl/roi_fft_pkg.sv | 26 ++
 rtl/roi_skid_fifo.sv | 57 +++++
 rtl/roi_fft_pass_engine.sv | 167 ++++++++++++++++
 tb/tb_roi_fft_pass_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roi_fft_pkg.sv
// Shared types and helpers for the ROI buffer FFT pass engine.
// Holds the pass state encoding, default geometry and row/col addressing.
package roi_fft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_ADDR_W     = 12;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_FFT_LEN    = 64;
    localparam int DEF_NUM_ROWS   = 64;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int unsigned rc_addr(
        input int unsigned row,
        input int unsigned col,
        input int unsigned stride
    );
        return row * stride + col;
    endfunction

endpackage

// File: rtl/roi_skid_fifo.sv
// Small synchronous FIFO absorbing BRAM read latency in front of m_axis.
// Flush empties it in one cycle; the head word is driven straight from storage.
module roi_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/roi_fft_pass_engine.sv
// One BRAM lane client for a single FFT pass: read, stream out, write back.
// Define ROI_TRANSPOSE_WR_EN to write results column-major (column pass).
module roi_fft_pass_engine
    import roi_fft_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FFT_LEN    = DEF_FFT_LEN,
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_tlast,
    output logic              bram_rden,
    output logic [ADDR_W-1:0] bram_rdaddr,
    input  logic [DATA_W-1:0] bram_rddata,
    output logic              bram_wren,
    output logic [ADDR_W-1:0] bram_wraddr,
    output logic [DATA_W-1:0] bram_wrdata,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast
);

    localparam int TOTAL = FFT_LEN * NUM_ROWS;
    localparam int CNT_W = ADDR_W + 1;
    localparam int COL_W = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ALL_IDX  = CNT_W'(TOTAL);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(FFT_LEN - 1);

    state_t            state;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [COL_W-1:0]  tx_col;
    logic              inflight;
    logic              m_fire;
    logic              s_fire;
    logic              exp_last;
    logic              wr_last;
    logic              fifo_flush;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic [ADDR_W-1:0] wr_addr;
    int unsigned       rd_idx;
    int unsigned       wr_idx;

`ifdef ROI_TRANSPOSE_WR_EN
    if (FFT_LEN != NUM_ROWS) begin : g_bad_geom
        $error("ROI_TRANSPOSE_WR_EN needs FFT_LEN == NUM_ROWS");
    end
`endif

    assign rd_idx = 32'(rd_cnt);
    assign wr_idx = 32'(wr_cnt);

    assign busy          = (state == RUN) || (state == DRAIN);
    assign done          = (state == DONE);
    assign s_axis_tready = busy;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = !fifo_empty;
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid && (tx_col == LAST_COL);

    // Credit covers both queued words and the read still in the BRAM pipe.
    assign bram_rden = (state == RUN) &&
                       ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);

    assign bram_rdaddr = ADDR_W'(rc_addr(rd_idx / FFT_LEN,
                                         rd_idx % FFT_LEN, FFT_LEN));

`ifdef ROI_TRANSPOSE_WR_EN
    assign wr_addr = ADDR_W'(rc_addr(wr_idx % FFT_LEN,
                                     wr_idx / FFT_LEN, NUM_ROWS));
`else
    assign wr_addr = ADDR_W'(rc_addr(wr_idx / FFT_LEN,
                                     wr_idx % FFT_LEN, FFT_LEN));
`endif

    assign exp_last   = (wr_idx % FFT_LEN) == 32'(FFT_LEN - 1);
    assign wr_last    = (wr_cnt == ALL_IDX);
    assign fifo_flush = (state == IDLE && start) ||
                        (state == DRAIN && bram_wren && wr_last);

    roi_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .flush (fifo_flush),
        .push  (inflight),
        .din   (bram_rddata),
        .pop   (m_fire),
        .dout  (m_axis_tdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            tx_col      <= '0;
            inflight    <= 1'b0;
            err_tlast   <= 1'b0;
            bram_wren   <= 1'b0;
            bram_wraddr <= '0;
            bram_wrdata <= '0;
        end else begin
            inflight  <= bram_rden;
            bram_wren <= s_fire;
            if (bram_rden) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (m_fire) begin
                tx_col <= (tx_col == LAST_COL) ? '0 : tx_col + 1'b1;
            end
            // Mismatched tlast is flagged but the write and the count go on.
            if (s_fire) begin
                wr_cnt      <= wr_cnt + 1'b1;
                bram_wraddr <= wr_addr;
                bram_wrdata <= s_axis_tdata;
                if (s_axis_tlast != exp_last) begin
                    err_tlast <= 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        rd_cnt    <= '0;
                        wr_cnt    <= '0;
                        tx_col    <= '0;
                        err_tlast <= 1'b0;
                    end
                end
                RUN: begin
                    if (bram_rden && rd_cnt == LAST_IDX) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bram_wren && wr_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_roi_fft_pass_engine.sv
// Bench for roi_fft_pass_engine with a BRAM model and an echoing FFT model.
// Honours ROI_TRANSPOSE_WR_EN (then uses a square 4x4 frame geometry).
module tb_roi_fft_pass_engine;

    localparam int FL  = 4;
`ifdef ROI_TRANSPOSE_WR_EN
    localparam int NR  = 4;
    localparam int EXP_WA6 = 9;
`else
    localparam int NR  = 2;
    localparam int EXP_WA6 = 6;
`endif
    localparam int TOT = FL * NR;
    localparam int DEP = 4;
    localparam int AW  = 12;
    localparam int DW  = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err_tlast;
    logic          bram_rden, bram_wren;
    logic [AW-1:0] bram_rdaddr, bram_wraddr;
    logic [DW-1:0] bram_rddata;
    logic [DW-1:0] bram_wrdata;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;

    always #5 clk = ~clk;

    roi_fft_pass_engine #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FFT_LEN    (FL),
        .NUM_ROWS   (NR),
        .FIFO_DEPTH (DEP)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rstn),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err_tlast     (err_tlast),
        .bram_rden     (bram_rden),
        .bram_rdaddr   (bram_rdaddr),
        .bram_rddata   (bram_rddata),
        .bram_wren     (bram_wren),
        .bram_wraddr   (bram_wraddr),
        .bram_wrdata   (bram_wrdata),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame geometry: beat k is row k/FL, column k%FL.
    function automatic int exp_wa(input int k);
        int row = k / FL;
        int col = k % FL;
`ifdef ROI_TRANSPOSE_WR_EN
        return col * NR + row;
`else
        return row * FL + col;
`endif
    endfunction

    // BRAM model: separate read image and write image per pass.
    logic [63:0] init_val [16];
    logic [63:0] rmem [16];
    logic [63:0] wmem [16];
    logic        preload = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                rmem[i] <= init_val[i];
                wmem[i] <= '0;
            end
        end
        if (bram_rden) bram_rddata <= rmem[bram_rdaddr[3:0]];
        if (bram_wren) wmem[bram_wraddr[3:0]] <= bram_wrdata;
    end

    // FFT model: echoes every sent word +1, tlast from its own beat count.
    logic [63:0] fq [$];
    int          out_k = 0;
    bit          bad_mode = 1'b0;
    bit          gap_mode = 1'b0;

    function automatic logic model_last(input int k);
        if (bad_mode && k == 2) return 1'b1;
        if (bad_mode && k == 3) return 1'b0;
        return (k % FL) == FL - 1;
    endfunction

    always @(posedge clk) begin
        if (!rstn || preload) begin
            fq.delete();
            s_axis_tvalid <= 1'b0;
            s_axis_tdata  <= '0;
            s_axis_tlast  <= 1'b0;
            out_k         <= 0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) fq.push_back(m_axis_tdata);
            if (s_axis_tvalid && s_axis_tready) out_k <= out_k + 1;
            if (!s_axis_tvalid || s_axis_tready) begin
                if (fq.size() > 0 && !(gap_mode && $urandom_range(3) == 0)) begin
                    s_axis_tdata  <= fq.pop_front() + 64'd1;
                    s_axis_tlast  <= model_last(out_k + int'(s_axis_tvalid));
                    s_axis_tvalid <= 1'b1;
                end else begin
                    s_axis_tvalid <= 1'b0;
                end
            end
        end
    end

    // Observers: counts and per-beat expectations from the model image.
    int          rd_n = 0, tx_n = 0, wr_n = 0, s_n = 0, done_n = 0;
    int          rd_err = 0, tx_err = 0, wr_err = 0, ovf_err = 0;
    int          max_out = 0;
    logic        err_pre = 1'b0, err_ok = 1'b0, chk_nx = 1'b0;
    logic [AW-1:0] cap_wa [16];

    always @(posedge clk) begin
        if (preload) begin
            rd_n <= 0; tx_n <= 0; wr_n <= 0; s_n <= 0; done_n <= 0;
            rd_err <= 0; tx_err <= 0; wr_err <= 0; ovf_err <= 0;
            max_out <= 0; err_pre <= 1'b0; err_ok <= 1'b0; chk_nx <= 1'b0;
        end else begin
            if (bram_rden) begin
                rd_n <= rd_n + 1;
                if (bram_rdaddr !== AW'(rd_n)) rd_err <= rd_err + 1;
                if (rd_n - tx_n >= DEP) ovf_err <= ovf_err + 1;
            end
            if (rd_n - tx_n > max_out) max_out <= rd_n - tx_n;
            if (m_axis_tvalid && m_axis_tready) begin
                tx_n <= tx_n + 1;
                if (m_axis_tdata !== rmem[tx_n % 16] ||
                    m_axis_tlast !== ((tx_n % FL) == FL - 1))
                    tx_err <= tx_err + 1;
            end
            if (bram_wren) begin
                wr_n <= wr_n + 1;
                cap_wa[wr_n % 16] <= bram_wraddr;
                if (bram_wraddr !== AW'(exp_wa(wr_n)) ||
                    bram_wrdata !== rmem[wr_n % 16] + 64'd1)
                    wr_err <= wr_err + 1;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                s_n <= s_n + 1;
                if (s_n == 2) err_pre <= err_tlast;
            end
            chk_nx <= s_axis_tvalid && s_axis_tready && s_n == 2;
            if (chk_nx) err_ok <= err_tlast;
            if (done) done_n <= done_n + 1;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, done, err_tlast, bram_rden,
              bram_wren, m_axis_tvalid, m_axis_tlast, s_axis_tready}), 0);
        check({tag, "_rdaddr"}, 64'(bram_rdaddr), 0);
        check({tag, "_wraddr"}, 64'(bram_wraddr), 0);
        check({tag, "_wrdata"}, bram_wrdata, 0);
        check({tag, "_tdata"}, m_axis_tdata, 0);
    endtask

    task automatic begin_pass(input int mode);
        for (int i = 0; i < 16; i++)
            init_val[i] = (mode == 2) ? {$urandom(), $urandom()}
                                      : 64'h100 + 64'(i);
        gap_mode = (mode == 2);
        m_axis_tready = 1'b1;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_pass(input int mode, input int poke);
        int cyc = 0;
        while (done_n == 0 && cyc < 2000) begin
            if (mode == 1) m_axis_tready = (cyc % 3 == 0);
            else if (mode == 2) m_axis_tready = 1'($urandom_range(1));
            else m_axis_tready = 1'b1;
            start = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
        check("done_seen", 64'(done_n != 0), 1);
        @(negedge clk);
        check("done_low_after", 64'(done), 0);
        check("busy_low_after", 64'(busy), 0);
        repeat (2) @(negedge clk);
        check("done_once", 64'(done_n), 1);
    endtask

    task automatic check_pass(input string tag);
        check({tag, "_reads"}, 64'(rd_n), 64'(TOT));
        check({tag, "_beats"}, 64'(tx_n), 64'(TOT));
        check({tag, "_writes"}, 64'(wr_n), 64'(TOT));
        check({tag, "_rdaddr_err"}, 64'(rd_err), 0);
        check({tag, "_tx_err"}, 64'(tx_err), 0);
        check({tag, "_wr_err"}, 64'(wr_err), 0);
        check({tag, "_credit_err"}, 64'(ovf_err), 0);
        for (int k = 0; k < TOT; k++)
            check({tag, "_mem"}, wmem[exp_wa(k)], init_val[k] + 64'd1);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Basic pass: latency, full rate, contents, write addressing.
        begin_pass(0);
        check("lat_rden", 64'(bram_rden), 1);
        check("lat_rdaddr", 64'(bram_rdaddr), 0);
        check("lat_busy", 64'(busy), 1);
        check("lat_tvalid_c1", 64'(m_axis_tvalid), 0);
        @(negedge clk);
        check("lat_tvalid_c2", 64'(m_axis_tvalid), 0);
        @(negedge clk);
        check("lat_tvalid_c3", 64'(m_axis_tvalid), 1);
        check("first_tdata", m_axis_tdata, 64'h100);
        repeat (TOT) @(negedge clk);
        check("full_rate", 64'(tx_n), 64'(TOT));
        finish_pass(0, -1);
        check_pass("basic");
        check("err_clean", 64'(err_tlast), 0);
        check("wa5", 64'(cap_wa[5]), 5);
        check("wa6", 64'(cap_wa[6]), 64'(EXP_WA6));

        // Backpressure 1,0,0 pattern must fill the credit window.
        begin_pass(1);
        finish_pass(1, -1);
        check_pass("bp");
        check("bp_max_out", 64'(max_out), 64'(DEP));

        // Misplaced tlast on beat 2.
        bad_mode = 1'b1;
        begin_pass(0);
        finish_pass(0, -1);
        check_pass("badlast");
        check("badlast_err_before", 64'(err_pre), 0);
        check("badlast_err_next", 64'(err_ok), 1);
        check("badlast_sticky", 64'(err_tlast), 1);
        bad_mode = 1'b0;
        begin_pass(0);
        check("err_cleared_by_start", 64'(err_tlast), 0);
        finish_pass(0, -1);
        check_pass("after_bad");

        // Reset mid-pass after three output beats.
        begin_pass(0);
        for (int c = 0; c < 200 && tx_n < 3; c++) @(negedge clk);
        check("abort_reached", 64'(tx_n >= 3), 1);
        rstn = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        rstn = 1'b1;
        @(negedge clk);
        begin_pass(0);
        finish_pass(0, -1);
        check_pass("post_reset");

        // start pulse while busy is ignored.
        begin_pass(0);
        finish_pass(0, 4);
        check_pass("start_busy");

        // Randomised data, tready and FFT gaps.
        for (int r = 0; r < 3; r++) begin
            begin_pass(2);
            finish_pass(2, -1);
            check_pass("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
